// File: rtl/dll_lock_ctrl_if.sv
// Control/status bundle between the FMDLL lock controller and its surroundings.
interface dll_lock_ctrl_if #(
    parameter int unsigned CODE_W = 10
);
    logic              en;
    logic              div_strobe;
    logic              comp;
    logic              pd_rst;
    logic [CODE_W-1:0] Q;
    logic              busy;
    logic              lock;
    logic              err;

    // Controller side: consumes enable/strobe/comparator, drives PD reset, code and status
    modport slave (
        input  en,
        input  div_strobe,
        input  comp,
        output pd_rst,
        output Q,
        output busy,
        output lock,
        output err
    );

    // Environment side: the reverse view
    modport master (
        output en,
        output div_strobe,
        output comp,
        input  pd_rst,
        input  Q,
        input  busy,
        input  lock,
        input  err
    );
endinterface

// File: rtl/dll_lock_ctrl.sv
// FMDLL lock controller: PD reset / settle sequencing, SAR acquisition of the
// delay code, then +/-1 tracking with lock/unlock and saturation error detection.
module dll_lock_ctrl #(
    parameter int unsigned CODE_W     = 10,
    parameter int unsigned SETTLE_CNT = 2,
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input  logic           clk_ext,
    input  logic           rst_n,
    dll_lock_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    localparam logic [CODE_W-1:0] Q_MAX      = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] Q_MID      = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  SETTLE_LIM = CNT_W'(SETTLE_CNT);
    localparam logic [CNT_W-1:0]  LOCK_LIM   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]  UNLOCK_LIM = CNT_W'(UNLOCK_CNT);
    localparam logic [IDX_W-1:0]  IDX_TOP    = IDX_W'(CODE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PDRST,
        S_SETTLE,
        S_SAR,
        S_TRACK
    } state_t;

    state_t             r_state,    w_state;
    logic               r_en_d;
    logic [CODE_W-1:0]  r_q,        w_q;
    logic [IDX_W-1:0]   r_idx,      w_idx;
    logic [CNT_W-1:0]   r_settle,   w_settle;
    logic [CNT_W-1:0]   r_rev,      w_rev;
    logic [CNT_W-1:0]   r_same,     w_same;
    logic               r_sar_done, w_sar_done;
    logic               r_have_dir, w_have_dir;
    logic               r_last_dir, w_last_dir;
    logic               r_lock,     w_lock;
    logic               r_err,      w_err;
    logic               r_pd_rst,   w_pd_rst;
    logic               r_busy,     w_busy;

    logic               w_en_rise;
    logic               w_at_lim;
    logic [CNT_W-1:0]   w_settle_inc;
    logic [CNT_W-1:0]   w_rev_inc;
    logic [CNT_W-1:0]   w_same_inc;
    logic [IDX_W-1:0]   w_idx_dec;

    // Helper arithmetic shared by the next-state logic; counters saturate instead of wrapping
    always_comb begin
        w_en_rise    = bus.en && !r_en_d;
        w_settle_inc = (r_settle == CNT_MAX) ? r_settle : r_settle + CNT_W'(1);
        w_rev_inc    = (r_rev    == CNT_MAX) ? r_rev    : r_rev    + CNT_W'(1);
        w_same_inc   = (r_same   == CNT_MAX) ? r_same   : r_same   + CNT_W'(1);
        w_idx_dec    = r_idx - IDX_W'(1);
        w_at_lim     = bus.comp ? (r_q == Q_MAX) : (r_q == '0);
    end

    // State register and all datapath/output registers
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_en_d     <= 1'b0;
            r_q        <= '0;
            r_idx      <= '0;
            r_settle   <= '0;
            r_rev      <= '0;
            r_same     <= '0;
            r_sar_done <= 1'b0;
            r_have_dir <= 1'b0;
            r_last_dir <= 1'b0;
            r_lock     <= 1'b0;
            r_err      <= 1'b0;
            r_pd_rst   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_en_d     <= bus.en;
            r_q        <= w_q;
            r_idx      <= w_idx;
            r_settle   <= w_settle;
            r_rev      <= w_rev;
            r_same     <= w_same;
            r_sar_done <= w_sar_done;
            r_have_dir <= w_have_dir;
            r_last_dir <= w_last_dir;
            r_lock     <= w_lock;
            r_err      <= w_err;
            r_pd_rst   <= w_pd_rst;
            r_busy     <= w_busy;
        end
    end

    // Next-state and next-output logic; an en drop outranks any coincident strobe
    always_comb begin
        w_state    = r_state;
        w_q        = r_q;
        w_idx      = r_idx;
        w_settle   = r_settle;
        w_rev      = r_rev;
        w_same     = r_same;
        w_sar_done = r_sar_done;
        w_have_dir = r_have_dir;
        w_last_dir = r_last_dir;
        w_lock     = r_lock;
        w_err      = r_err;

        if ((r_state != S_IDLE) && !bus.en) begin
            w_state = S_IDLE;
            w_lock  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_en_rise) begin
                        w_q        = Q_MID;
                        w_idx      = IDX_TOP;
                        w_lock     = 1'b0;
                        w_err      = 1'b0;
                        w_sar_done = 1'b0;
                        w_state    = S_PDRST;
                    end
                end

                S_PDRST: begin
                    w_settle = '0;
                    w_state  = S_SETTLE;
                end

                S_SETTLE: begin
                    if (bus.div_strobe) begin
                        if (w_settle_inc >= SETTLE_LIM) begin
                            w_settle = '0;
                            w_state  = r_sar_done ? S_TRACK : S_SAR;
                        end else begin
                            w_settle = w_settle_inc;
                        end
                    end
                end

                S_SAR: begin
                    if (bus.div_strobe) begin
                        if (!bus.comp) begin
                            w_q[r_idx] = 1'b0;
                        end
                        if (r_idx != '0) begin
                            w_q[w_idx_dec] = 1'b1;
                            w_idx          = w_idx_dec;
                        end else begin
                            w_sar_done = 1'b1;
                            w_have_dir = 1'b0;
                            w_rev      = '0;
                            w_same     = '0;
                        end
                        w_state = S_PDRST;
                    end
                end

                S_TRACK: begin
                    if (bus.div_strobe) begin
                        if (!w_at_lim) begin
                            w_q = bus.comp ? (r_q + CODE_W'(1)) : (r_q - CODE_W'(1));
                        end
                        if (r_have_dir) begin
                            if (bus.comp != r_last_dir) begin
                                w_rev  = w_rev_inc;
                                w_same = '0;
                            end else begin
                                w_same = w_same_inc;
                                w_rev  = '0;
                            end
                        end
                        w_have_dir = 1'b1;
                        w_last_dir = bus.comp;
                        if (w_rev == LOCK_LIM) begin
                            w_lock = 1'b1;
                        end
                        if (r_lock && (w_same == UNLOCK_LIM)) begin
                            w_lock = 1'b0;
                            w_rev  = '0;
                        end
                        if (w_at_lim && (w_same >= UNLOCK_LIM)) begin
                            w_err  = 1'b1;
                            w_lock = 1'b0;
                        end
                        w_state = S_PDRST;
                    end
                end

                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end

        w_pd_rst = (w_state == S_IDLE) || (w_state == S_PDRST);
        w_busy   = (w_state != S_IDLE);
    end

    assign bus.Q      = r_q;
    assign bus.pd_rst = r_pd_rst;
    assign bus.busy   = r_busy;
    assign bus.lock   = r_lock;
    assign bus.err    = r_err;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Scoreboard bench for dll_lock_ctrl: each decision strobe pushes the expected
// code/lock/err seen in the following PD-reset cycle; a monitor pops and compares.
module tb_dll_lock_ctrl;
    localparam int unsigned CODE_W = 10;

    typedef struct packed {
        logic [CODE_W-1:0] q;
        logic              lock;
        logic              err;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q_exp[$];
    int   n_checks;
    int   n_err;
    logic exp_busy;
    int   busy_low;

    dll_lock_ctrl_if #(.CODE_W(CODE_W)) bus ();

    dll_lock_ctrl #(
        .CODE_W    (CODE_W),
        .SETTLE_CNT(2),
        .LOCK_CNT  (8),
        .UNLOCK_CNT(4)
    ) dut (
        .clk_ext(clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int q, input logic l, input logic e);
        exp_t x;
        x.q    = CODE_W'(q);
        x.lock = l;
        x.err  = e;
        q_exp.push_back(x);
    endtask

    task automatic strobe(input logic c);
        bus.div_strobe = 1'b1;
        bus.comp       = c;
        @(negedge clk);
        bus.div_strobe = 1'b0;
        bus.comp       = 1'b0;
    endtask

    // Two settle strobes carrying the opposite comp, then the deciding strobe
    task automatic decide(input logic c, input int eq, input logic el, input logic ee);
        repeat (2) begin
            tick(7);
            strobe(!c);
        end
        tick(7);
        push_exp(eq, el, ee);
        strobe(c);
    endtask

    task automatic start_run();
        bus.en = 1'b1;
        push_exp(512, 1'b0, 1'b0);
        tick(1);
        exp_busy = 1'b1;
    endtask

    task automatic stop_run();
        exp_busy = 1'b0;
        bus.en   = 1'b0;
        tick(2);
    endtask

    // Monitor: every PD-reset cycle while busy must match the next queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_busy && !bus.busy) busy_low++;
            if (rst_n && bus.busy && bus.pd_rst) begin
                if (q_exp.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL pdrst_unexpected: got PD reset with no queued decision (t=%0t)", $time);
                end else begin
                    e = q_exp.pop_front();
                    check("pdrst_q",    32'(bus.Q),    32'(e.q));
                    check("pdrst_lock", 32'(bus.lock), 32'(e.lock));
                    check("pdrst_err",  32'(bus.err),  32'(e.err));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sar300 [10];
        int sar1023 [10];
        int trk [9];
        int cur;
        int dev;

        sar300  = '{256, 384, 320, 288, 304, 296, 300, 298, 299, 299};
        sar1023 = '{768, 896, 960, 992, 1008, 1016, 1020, 1022, 1023, 1023};
        trk     = '{300, 299, 300, 299, 300, 299, 300, 299, 300};

        n_checks = 0;
        n_err    = 0;
        busy_low = 0;
        exp_busy = 1'b0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.div_strobe = 1'b0;
        bus.comp = 1'b0;

        // Reset and idle
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_q",      32'(bus.Q),      0);
        check("rst_pd_rst", 32'(bus.pd_rst), 1);
        check("rst_busy",   32'(bus.busy),   0);
        check("rst_lock",   32'(bus.lock),   0);
        check("rst_err",    32'(bus.err),    0);
        dev = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bus.Q !== '0 || bus.pd_rst !== 1'b1 || bus.busy !== 1'b0 ||
                bus.lock !== 1'b0 || bus.err !== 1'b0) dev++;
        end
        check("idle_stable_deviations", 32'(dev), 0);

        // SAR towards 300, then tracking to lock, then forced unlock
        start_run();
        cur = 512;
        for (int i = 0; i < 10; i++) begin
            decide(logic'(cur < 300), sar300[i], 1'b0, 1'b0);
            cur = sar300[i];
        end
        check("sar_busy_low_cycles", 32'(busy_low), 0);
        for (int k = 0; k < 9; k++) begin
            decide(logic'(cur < 300), trk[k], logic'(k == 8), 1'b0);
            cur = trk[k];
        end
        decide(1'b1, 301, 1'b1, 1'b0);
        decide(1'b1, 302, 1'b1, 1'b0);
        decide(1'b1, 303, 1'b1, 1'b0);
        decide(1'b1, 304, 1'b0, 1'b0);
        decide(1'b0, 303, 1'b0, 1'b0);
        check("track_busy_low_cycles", 32'(busy_low), 0);
        stop_run();

        // Saturation at the top code raises err
        start_run();
        for (int i = 0; i < 10; i++) decide(1'b1, sar1023[i], 1'b0, 1'b0);
        decide(1'b1, 1023, 1'b0, 1'b0);
        decide(1'b1, 1023, 1'b0, 1'b0);
        decide(1'b1, 1023, 1'b0, 1'b0);
        decide(1'b1, 1023, 1'b0, 1'b0);
        decide(1'b1, 1023, 1'b0, 1'b1);
        stop_run();
        check("sat_idle_err",  32'(bus.err),  1);
        check("sat_idle_busy", 32'(bus.busy), 0);
        check("sat_idle_q",    32'(bus.Q),    1023);

        // Restart clears err; abort at the 5th SAR decision
        start_run();
        cur = 512;
        for (int i = 0; i < 4; i++) begin
            decide(logic'(cur < 300), sar300[i], 1'b0, 1'b0);
            cur = sar300[i];
        end
        repeat (2) begin
            tick(7);
            strobe(1'b0);
        end
        tick(7);
        exp_busy = 1'b0;
        bus.en   = 1'b0;
        strobe(logic'(cur < 300));
        check("abort_busy",   32'(bus.busy),   0);
        check("abort_pd_rst", 32'(bus.pd_rst), 1);
        check("abort_q",      32'(bus.Q),      288);
        check("abort_lock",   32'(bus.lock),   0);
        tick(3);

        // Full reacquisition, a little tracking, then asynchronous reset
        start_run();
        cur = 512;
        for (int i = 0; i < 10; i++) begin
            decide(logic'(cur < 300), sar300[i], 1'b0, 1'b0);
            cur = sar300[i];
        end
        decide(1'b1, 300, 1'b0, 1'b0);
        decide(1'b0, 299, 1'b0, 1'b0);
        tick(3);
        exp_busy = 1'b0;
        #2;
        rst_n  = 1'b0;
        bus.en = 1'b0;
        #1;
        check("arst_q",      32'(bus.Q),      0);
        check("arst_pd_rst", 32'(bus.pd_rst), 1);
        check("arst_busy",   32'(bus.busy),   0);
        check("arst_lock",   32'(bus.lock),   0);
        check("arst_err",    32'(bus.err),    0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("queue_drained", 32'(q_exp.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
